// File: rtl/sort_pkg.sv
// Shared definitions for the sort engine and its job scheduler: default
// geometry and the scheduler state encoding.
package sort_pkg;

  localparam int SORT_MM = 256;
  localparam int SORT_MN = 32;
  localparam int SORT_MW = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_SORT  = 3'd3,
    ST_DRAIN = 3'd4
  } sched_state_e;

endpackage

// File: rtl/sort_job_sched_if.sv
// Host-side streams of the sort job scheduler: load words in, sorted words out.
// Both streams use valid/ready: a beat transfers on a clock edge where valid
// and ready are both high; the sender holds valid and its payload until then.
interface sort_job_sched_if #(
  parameter int MN = 32
);

  logic          in_valid;
  logic          in_ready;
  logic [MN-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [MN-1:0] out_data;
  logic          out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/sort_out_buf2.sv
// Two-entry FIFO feeding the sorted output stream; entry 0 is always the head,
// so the presented word stays put while the consumer stalls.
module sort_out_buf2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic         valid,
  output logic [W-1:0] data
);

  logic [W-1:0] e0, e1;
  logic [1:0]   cnt_q;
  logic         do_pop, do_push;

  assign do_pop  = pop && (cnt_q != 2'd0);
  assign do_push = push && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e0    <= '0;
      e1    <= '0;
      cnt_q <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0 <= push_data;
          else               e1 <= push_data;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0 <= push_data;
          end else begin
            e0 <= e1;
            e1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = cnt_q;
  assign valid = (cnt_q != 2'd0);
  assign data  = e0;

endmodule

// File: rtl/sort_job_sched.sv
// Job sequencer around the quick-sort engine: load, sort, drain over one memory port.
// Define SORT_DESCEND_EN to drain from the top address down (descending output).
module sort_job_sched
  import sort_pkg::*;
#(
  parameter int MM = SORT_MM,
  parameter int MN = SORT_MN,
  parameter int MW = SORT_MW
) (
  input  logic          clk,
  input  logic          reset_n,
  sort_job_sched_if.slave host,
  output logic          busy,
  output logic [MW:0]   srt_num,
  output logic          srt_start,
  input  logic          srt_done,
  input  logic          srt_MemWr,
  input  logic [MW-1:0] srt_MemWrAddr,
  input  logic [MN-1:0] srt_MemWrData,
  input  logic          srt_MemRd,
  input  logic [MW-1:0] srt_MemRdAddr,
  output logic [MN-1:0] srt_MemRdData,
  output logic          MemWr,
  output logic [MW-1:0] MemWrAddr,
  output logic [MN-1:0] MemWrData,
  output logic          MemRd,
  output logic [MW-1:0] MemRdAddr,
  input  logic [MN-1:0] MemRdData,
  output sched_state_e  dbg_state
);

  localparam logic [MW:0] CNT_FULL = (MW+1)'(MM);
  localparam logic [MW:0] CNT_TWO  = (MW+1)'(2);

  sched_state_e  state;
  logic [MW:0]   wcnt, cnt, rd_cnt, wnext;
  logic          rd_inflight, rd_inflight_last;
  logic          in_ready_int, accept, wlast, drain_rd, pop;
  logic [1:0]    buf_cnt;
  logic          buf_valid;
  logic [MN:0]   buf_head;
  logic [MW-1:0] drain_addr;

  // Gating with reset_n keeps every output low while reset is held.
  assign in_ready_int  = reset_n && ((state == ST_IDLE) || (state == ST_LOAD));
  assign host.in_ready = in_ready_int;
  assign accept        = host.in_valid && in_ready_int;
  assign wnext         = wcnt + 1'b1;
  assign wlast         = host.in_last || (wnext == CNT_FULL);

  // Reads in flight plus words buffered may not exceed the two buffer slots;
  // a pop this cycle frees a slot so a full-rate stream never bubbles.
  assign pop      = buf_valid && host.out_ready;
  assign drain_rd = (state == ST_DRAIN) && (rd_cnt != cnt) &&
                    (({1'b0, rd_inflight} + buf_cnt - {1'b0, pop}) < 2'd2);

`ifdef SORT_DESCEND_EN
  assign drain_addr = MW'(cnt - rd_cnt - 1'b1);
`else
  assign drain_addr = rd_cnt[MW-1:0];
`endif

  always_comb begin
    MemWr         = 1'b0;
    MemWrAddr     = '0;
    MemWrData     = '0;
    MemRd         = 1'b0;
    MemRdAddr     = '0;
    srt_MemRdData = '0;
    if (state == ST_SORT) begin
      MemWr         = srt_MemWr;
      MemWrAddr     = srt_MemWrAddr;
      MemWrData     = srt_MemWrData;
      MemRd         = srt_MemRd;
      MemRdAddr     = srt_MemRdAddr;
      srt_MemRdData = MemRdData;
    end else begin
      MemWr = accept;
      MemRd = drain_rd;
      if (accept) begin
        MemWrAddr = wcnt[MW-1:0];
        MemWrData = host.in_data;
      end
      if (drain_rd) MemRdAddr = drain_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      wcnt             <= '0;
      cnt              <= '0;
      rd_cnt           <= '0;
      rd_inflight      <= 1'b0;
      rd_inflight_last <= 1'b0;
    end else begin
      rd_inflight      <= drain_rd;
      rd_inflight_last <= drain_rd && (rd_cnt == cnt - 1'b1);
      if (drain_rd) rd_cnt <= rd_cnt + 1'b1;
      case (state)
        ST_IDLE, ST_LOAD: begin
          if (accept) begin
            if (wlast) begin
              cnt    <= wnext;
              wcnt   <= '0;
              rd_cnt <= '0;
              state  <= (wnext >= CNT_TWO) ? ST_START : ST_DRAIN;
            end else begin
              wcnt  <= wnext;
              state <= ST_LOAD;
            end
          end
        end
        ST_START: state <= ST_SORT;
        ST_SORT:  if (srt_done) state <= ST_DRAIN;
        ST_DRAIN: if (pop && buf_head[MN]) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  sort_out_buf2 #(.W(MN + 1)) u_out_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rd_inflight),
    .push_data ({rd_inflight_last, MemRdData}),
    .pop       (pop),
    .count     (buf_cnt),
    .valid     (buf_valid),
    .data      (buf_head)
  );

  assign host.out_valid = buf_valid;
  assign host.out_data  = buf_head[MN-1:0];
  assign host.out_last  = buf_head[MN];

  assign busy      = (state != ST_IDLE);
  assign srt_start = (state == ST_START);
  assign srt_num   = cnt;
  assign dbg_state = state;

endmodule

// File: tb/tb_sort_job_sched.sv
// Directed bench for sort_job_sched with a behavioural memory and a simple
// engine stand-in that sorts through the scheduler's engine port.
module tb_sort_job_sched;
  import sort_pkg::*;

  localparam int MM = 256;
  localparam int MN = 32;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          busy;
  logic [MW:0]   srt_num;
  logic          srt_start;
  logic          srt_done;
  logic          srt_MemWr;
  logic [MW-1:0] srt_MemWrAddr;
  logic [MN-1:0] srt_MemWrData;
  logic          srt_MemRd;
  logic [MW-1:0] srt_MemRdAddr;
  logic [MN-1:0] srt_MemRdData;
  logic          MemWr;
  logic [MW-1:0] MemWrAddr;
  logic [MN-1:0] MemWrData;
  logic          MemRd;
  logic [MW-1:0] MemRdAddr;
  logic [MN-1:0] MemRdData;
  sched_state_e  dbg_state;

  sort_job_sched_if #(.MN(MN)) host ();

  sort_job_sched #(.MM(MM), .MN(MN), .MW(MW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .host          (host),
    .busy          (busy),
    .srt_num       (srt_num),
    .srt_start     (srt_start),
    .srt_done      (srt_done),
    .srt_MemWr     (srt_MemWr),
    .srt_MemWrAddr (srt_MemWrAddr),
    .srt_MemWrData (srt_MemWrData),
    .srt_MemRd     (srt_MemRd),
    .srt_MemRdAddr (srt_MemRdAddr),
    .srt_MemRdData (srt_MemRdData),
    .MemWr         (MemWr),
    .MemWrAddr     (MemWrAddr),
    .MemWrData     (MemWrData),
    .MemRd         (MemRd),
    .MemRdAddr     (MemRdAddr),
    .MemRdData     (MemRdData),
    .dbg_state     (dbg_state)
  );

  // clock / reset infrastructure
  always #5 clk = ~clk;

  logic [MN-1:0] mem [MM];
  logic [MN-1:0] mem_rdata = '0;
  int            wr_total = 0;
  int            start_total = 0;

  always @(posedge clk) begin
    if (MemWr) begin
      mem[MemWrAddr] <= MemWrData;
      wr_total <= wr_total + 1;
    end
    if (MemRd) mem_rdata <= mem[MemRdAddr];
    if (srt_start) start_total <= start_total + 1;
  end
  assign MemRdData = mem_rdata;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int            n_checks = 0;
  int            n_fail = 0;
  logic [MN-1:0] load_q[$];
  logic [MN-1:0] exp_q[$];
  bit            stall_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic load_job(input bit use_last);
    int n = load_q.size();
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      host.in_valid = 1'b1;
      host.in_data  = load_q[i];
      host.in_last  = use_last && (i == n - 1);
      #1;
      if (!host.in_ready) bad++;
    end
    @(negedge clk);
    host.in_valid = 1'b0;
    host.in_last  = 1'b0;
    #1;
    check_val("in_ready_during_load", bad, 0);
    check_val("in_ready_after_load", host.in_ready, 1'b0);
  endtask

  task automatic wait_start(input int n);
    int t = 0;
    while (!srt_start && t < 8) begin
      @(negedge clk);
      #1;
      t++;
    end
    check_val("srt_start_seen", srt_start, 1'b1);
    check_val("srt_num", srt_num, n);
  endtask

  task automatic run_engine(input int n);
    logic [MN-1:0] a[$];
    for (int i = 0; i <= n; i++) begin
      if (i > 0) a.push_back(srt_MemRdData);
      srt_MemRd     = (i < n);
      srt_MemRdAddr = MW'(i);
      @(negedge clk);
    end
    srt_MemRd = 1'b0;
    for (int i = 1; i < n; i++) begin
      logic [MN-1:0] k;
      int j;
      k = a[i];
      j = i - 1;
      while (j >= 0 && a[j] > k) begin
        a[j+1] = a[j];
        j--;
      end
      a[j+1] = k;
    end
    check_val("srt_num_held", srt_num, n);
    for (int i = 0; i < n; i++) begin
      srt_MemWr     = 1'b1;
      srt_MemWrAddr = MW'(i);
      srt_MemWrData = a[i];
      @(negedge clk);
    end
    srt_MemWr = 1'b0;
    srt_done  = 1'b1;
    @(negedge clk);
    srt_done  = 1'b0;
  endtask

  task automatic drain(input int n, input bit stall, output int first_lat);
    int got = 0;
    int cyc = 0;
    bit held_v = 1'b0;
    logic [MN-1:0] held_d = '0;
    logic [MN-1:0] e;
    first_lat = -1;
    while (got < n && cyc < n * 4 + 40) begin
      host.out_ready = stall ? stall_pat[cyc % 4] : 1'b1;
      #1;
      if (host.out_valid) begin
        if (first_lat < 0) first_lat = cyc;
        if (held_v) check_val("out_data_held", host.out_data, held_d);
        if (host.out_ready) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
          check_val("out_data", host.out_data, e);
          check_val("out_last", host.out_last, (got == n - 1));
          got++;
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held_d = host.out_data;
        end
      end
      @(negedge clk);
      cyc++;
    end
    host.out_ready = 1'b0;
    check_val("drain_word_count", got, n);
    #1;
    check_val("busy_after_drain", busy, 1'b0);
    check_val("state_after_drain", dbg_state, ST_IDLE);
  endtask

  initial begin
    int lat, s0, w0;
    reset_n        = 1'b0;
    host.in_valid  = 1'b0;
    host.in_data   = '0;
    host.in_last   = 1'b0;
    host.out_ready = 1'b0;
    srt_done       = 1'b0;
    srt_MemWr      = 1'b0;
    srt_MemWrAddr  = '0;
    srt_MemWrData  = '0;
    srt_MemRd      = 1'b0;
    srt_MemRdAddr  = '0;
    for (int i = 0; i < MM; i++) mem[i] = '0;

    repeat (3) @(negedge clk);
    #1;
    check_val("rst_in_ready", host.in_ready, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_out_valid", host.out_valid, 1'b0);
    check_val("rst_srt_num", srt_num, 0);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check_val("idle_in_ready", host.in_ready, 1'b1);
    check_val("idle_state", dbg_state, ST_IDLE);

    // four words, in_last on the fourth
    load_q = '{32'd5, 32'd3, 32'd8, 32'd1};
`ifdef SORT_DESCEND_EN
    exp_q  = '{32'd8, 32'd5, 32'd3, 32'd1};
`else
    exp_q  = '{32'd1, 32'd3, 32'd5, 32'd8};
`endif
    s0 = start_total;
    load_job(1'b1);
    wait_start(4);
    @(negedge clk);
    run_engine(4);
    drain(4, 1'b0, lat);
    check_val("first_out_latency", lat, 2);
    check_val("start_pulses_job1", start_total - s0, 1);

    // single word: no sort, engine traffic in DRAIN must be ignored
    load_q = '{32'd42};
    exp_q  = '{32'd42};
    s0 = start_total;
    load_job(1'b1);
    check_val("single_state", dbg_state, ST_DRAIN);
    srt_MemWr     = 1'b1;
    srt_MemWrAddr = 8'd3;
    srt_MemWrData = 32'hDEAD_BEEF;
    srt_MemRd     = 1'b1;
    w0 = wr_total;
    #1;
    check_val("drain_memwr_blocked", MemWr, 1'b0);
    drain(1, 1'b0, lat);
    check_val("single_latency", lat, 2);
    check_val("drain_mem_writes", wr_total - w0, 0);
    check_val("start_pulses_single", start_total - s0, 0);
    srt_MemWr = 1'b0;
    srt_MemRd = 1'b0;
    @(negedge clk);
    srt_done = 1'b1;
    @(negedge clk);
    srt_done = 1'b0;
    #1;
    check_val("idle_srt_done_state", dbg_state, ST_IDLE);
    check_val("idle_srt_done_busy", busy, 1'b0);

    // 256 beats without in_last; data is a permutation of 0..255
    load_q.delete();
    exp_q.delete();
    for (int i = 0; i < MM; i++) load_q.push_back(MN'((i * 37 + 11) % 256));
`ifdef SORT_DESCEND_EN
    for (int k = 0; k < MM; k++) exp_q.push_back(MN'(255 - k));
`else
    for (int k = 0; k < MM; k++) exp_q.push_back(MN'(k));
`endif
    load_job(1'b0);
    wait_start(256);
    @(negedge clk);
    run_engine(256);
    drain(256, 1'b0, lat);
    check_val("full_latency", lat, 2);

    // stalled output stream
    load_q = '{32'd20, 32'd10, 32'd40, 32'd30, 32'd50};
`ifdef SORT_DESCEND_EN
    exp_q  = '{32'd50, 32'd40, 32'd30, 32'd20, 32'd10};
`else
    exp_q  = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50};
`endif
    load_job(1'b1);
    wait_start(5);
    @(negedge clk);
    run_engine(5);
    drain(5, 1'b1, lat);

    // reset in the middle of SORT
    load_q = '{32'd7, 32'd2, 32'd9};
    load_job(1'b1);
    wait_start(3);
    @(negedge clk);
    srt_MemWr     = 1'b1;
    srt_MemWrAddr = 8'd1;
    srt_MemWrData = 32'h55;
    #1;
    check_val("sort_memwr_pass", MemWr, 1'b1);
    check_val("sort_memwr_data", MemWrData, 32'h55);
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_busy", busy, 1'b0);
    check_val("mid_rst_memwr", MemWr, 1'b0);
    check_val("mid_rst_srt_num", srt_num, 0);
    check_val("mid_rst_in_ready", host.in_ready, 1'b0);
    check_val("mid_rst_state", dbg_state, ST_IDLE);
    @(negedge clk);
    srt_MemWr = 1'b0;
    reset_n   = 1'b1;
    load_q = '{32'd6, 32'd4, 32'd2};
`ifdef SORT_DESCEND_EN
    exp_q  = '{32'd6, 32'd4, 32'd2};
`else
    exp_q  = '{32'd2, 32'd4, 32'd6};
`endif
    load_job(1'b1);
    wait_start(3);
    @(negedge clk);
    run_engine(3);
    drain(3, 1'b0, lat);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sort_job_sched.md
Name: sort_job_sched

Overview:
- Job-level sequencer wrapped around the in-place quick-sort engine and its MM x MN sort memory.
- Loads a stream of words into memory and starts the engine with the loaded count.
- Owns the single memory port and muxes it between its own load/drain logic and the engine.
- Drains the sorted array as a valid/ready output stream. Sits between the host streaming fabric and the sort engine.

Parameters:
- MM, 256, memory depth (words); power of two
- MN, 32, data word width
- MW, 8, log2(MM); address width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  load word valid
- in_ready  out  1  load word accepted when in_valid&&in_ready
- in_data  in  MN  load word
- in_last  in  1  marks final word of job
- out_valid  out  1  sorted word valid
- out_ready  in  1  downstream accepts
- out_data  out  MN  sorted word
- out_last  out  1  final sorted word
- busy  out  1  high in any state other than IDLE
- srt_num  out  MW+1  element count to engine
- srt_start  out  1  one-cycle engine start pulse
- srt_done  in  1  engine done pulse
- srt_MemWr/srt_MemWrAddr/srt_MemWrData  in  1/MW/MN  engine write request
- srt_MemRd/srt_MemRdAddr  in  1/MW  engine read request
- srt_MemRdData  out  MN  read data returned to engine
- MemWr/MemWrAddr/MemWrData  out  1/MW/MN  memory write port
- MemRd/MemRdAddr  out  1/MW  memory read port
- MemRdData  in  MN  memory read data, valid one cycle after MemRd

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, counters 0, output buffer empty.
- FSM states: IDLE, LOAD, START, SORT, DRAIN.
  - IDLE -> LOAD on the first in_valid; in_ready is 1 in IDLE and LOAD, so that first beat is accepted in IDLE.
  - LOAD: each accepted beat writes MemWrAddr=wcnt, MemWrData=in_data, then wcnt+1.
    - Leave LOAD when the beat carries in_last, or when wcnt reaches MM (the MM-th beat ends the job even without in_last).
    - Go to START if the final count >= 2, else go to DRAIN directly (no sort for 1 element).
  - START: srt_num = count (held stable through SORT); srt_start=1 for exactly one cycle; -> SORT.
  - SORT: memory port = engine port, combinationally passed through; srt_MemRdData = MemRdData. Stay until srt_done; -> DRAIN.
  - DRAIN: read addresses 0..count-1 in order; return to IDLE after the beat with out_last is accepted.
- Memory mux: the engine drives the memory only in SORT. Engine requests outside SORT are ignored. In all other states srt_MemRdData = 0.
- Drain pipeline: 1-cycle read latency; 2-entry output buffer (sort_out_buf2).
  - Issue a read when issued-but-unconsumed count (in-flight + buffered) < 2 and reads remain.
  - Sustains 1 word/cycle when out_ready is held high. First out_valid appears 2 cycles after DRAIN entry.
  - out_data/out_last are stable while out_valid && !out_ready.
  - out_last is asserted on element count-1.
- Counts are MW+1 bits; count = MM is legal. Addresses use the low MW bits.
- Load end conditions: in_last on the MM-th beat is the same as reaching MM. in_valid during START/SORT/DRAIN is not accepted (in_ready=0).
- srt_done outside SORT is ignored.
- Reset mid-job: immediate return to IDLE. Memory content is not cleared. The engine is reset by the same reset_n.

Optional Feature:
- SORT_DESCEND_EN defined: DRAIN reads addresses count-1 down to 0, giving descending output; out_last is on address 0.
- Not defined: ascending order, as described above.

Decomposition:
- Shared package sort_pkg: FSM state encoding localparams and default MM/MN/MW. The quick-sort engine also uses sort_pkg.
- One sub-module, sort_out_buf2: 2-entry valid/ready FIFO with push, pop, count and data.

Test Plan:
- Load 5,3,8,1 with in_last on 1 -> srt_num=4, one srt_start pulse; after srt_done, output 1,3,8,5? no: output 1,3,5,8 with out_last on 8; busy drops next cycle.
- Single word 42 with in_last -> no srt_start; out 42 with out_last; IDLE afterwards.
- 256 beats, in_last never asserted -> in_ready drops after beat 256; srt_num=256; output is an ascending sequence of 256 words.
- During DRAIN, toggle out_ready 1,0,0,1 -> no duplicated or lost words; out_data is held while stalled.
- Engine issues MemWr during DRAIN, and srt_done is pulsed in IDLE -> memory sees no write; no state change.
- reset_n low mid-SORT -> all outputs 0 asynchronously; a new job afterwards completes correctly. With SORT_DESCEND_EN, the first test outputs 8,5,3,1.
